// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode seven-segment scanner.
// Double-buffers a 16-bit hex value (pending -> shadow at frame boundaries), scans one digit per
// SCAN_DIV-cycle slot and blanks the first BLANK_CYCLES of every slot to suppress ghosting.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CntMax = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic          r_pend;
  logic [15:0]   r_pend_data;
  logic [3:0]    r_pend_dp;
  logic [3:0]    r_pend_en;

  logic [15:0]   r_sh_data;
  logic [3:0]    r_sh_dp;
  logic [3:0]    r_sh_en;

  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;

  assign w_wrap     = (r_cnt == CntMax);
  assign w_boundary = w_wrap && (r_idx == 2'd3);

  // With no blanking the compare would be constant-false, so drop it entirely.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BlankW = CW'(BLANK_CYCLES);
    assign w_blank = (r_cnt < BlankW);
  end

  // Slot prescaler and digit index; idx wraps 3 -> 0 by 2-bit overflow.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending/shadow double buffer; a load in the boundary cycle bypasses pending.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_en   <= '0;
      r_sh_data   <= '0;
      r_sh_dp     <= '0;
      r_sh_en     <= '0;
    end else if (w_boundary) begin
      if (load) begin
        r_sh_data <= data_in;
        r_sh_dp   <= dp_in;
        r_sh_en   <= digit_en;
      end else if (r_pend) begin
        r_sh_data <= r_pend_data;
        r_sh_dp   <= r_pend_dp;
        r_sh_en   <= r_pend_en;
      end
      r_pend <= 1'b0;
    end else if (load) begin
      r_pend_data <= data_in;
      r_pend_dp   <= dp_in;
      r_pend_en   <= digit_en;
      r_pend      <= 1'b1;
    end
  end

  // Select the current digit's nibble and decode it to active-low {g..a}.
  always_comb begin
    w_nib     = r_sh_data[{r_idx, 2'b00} +: 4];
    w_seg_dec = 7'h7F;
    unique case (w_nib)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
    endcase
  end

  // Registered display outputs; dark during blanking or when the digit is disabled.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_an          <= 4'hF;
      r_seg         <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if (w_blank || !r_sh_en[r_idx]) begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= w_seg_dec;
        r_dp  <= ~r_sh_dp[r_idx];
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver. Three instances share stimulus:
// main (SCAN_DIV=8, BLANK=2), z (SCAN_DIV=8, BLANK=0), t (SCAN_DIV=2, BLANK=1).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;

  logic [3:0] an_m, an_z, an_t;
  logic [6:0] seg_m, seg_z, seg_t;
  logic       dp_m, dp_z, dp_t;
  logic       fs_m, fs_z, fs_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut_m (
    .clk_in(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an_m), .seg(seg_m), .dp(dp_m), .frame_start(fs_m)
  );

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut_z (
    .clk_in(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an_z), .seg(seg_z), .dp(dp_z), .frame_start(fs_z)
  );

  seg_scan_driver #(.SCAN_DIV(2), .BLANK_CYCLES(1)) dut_t (
    .clk_in(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an_t), .seg(seg_t), .dp(dp_t), .frame_start(fs_t)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dp} for slot s, in-slot cycle c, given the shadow contents.
  function automatic logic [11:0] exp_out(input logic [15:0] d, input logic [3:0] dpv,
                                          input logic [3:0] en, input int s, input int c,
                                          input int blank);
    logic [3:0] a;
    if (c < blank || en[s] == 1'b0) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[s] = 1'b0;
    return {a, seg_of(d[s*4 +: 4]), ~dpv[s]};
  endfunction

  // Bounded wait for a frame_start pulse on one instance (0=m, 1=z, 2=t).
  task automatic wait_fs(input int which);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      case (which)
        0: got = fs_m;
        1: got = fs_z;
        default: got = fs_t;
      endcase
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wait_fs dut=%0d: got no frame_start, required one within 200 cycles", which);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] en);
    data_in = d;
    dp_in = dpv;
    digit_en = en;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    int first_m, first_z, first_t;
    logic lit;
    @(negedge clk);
    checks++;
    if ({an_m, seg_m, dp_m, fs_m} !== {4'hF, 7'h7F, 1'b1, 1'b0} ||
        {an_z, seg_z, dp_z, fs_z} !== {4'hF, 7'h7F, 1'b1, 1'b0} ||
        {an_t, seg_t, dp_t, fs_t} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got an=%h seg=%h dp=%b fs=%b, required an=f seg=7f dp=1 fs=0",
               an_m, seg_m, dp_m, fs_m);
    end
    rst = 1'b0;
    first_m = -1; first_z = -1; first_t = -1; lit = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (fs_m && first_m < 0) first_m = k;
      if (fs_z && first_z < 0) first_z = k;
      if (fs_t && first_t < 0) first_t = k;
      if (an_m !== 4'hF || an_z !== 4'hF || an_t !== 4'hF) lit = 1'b1;
    end
    checks++;
    if (lit !== 1'b0) begin
      failures++;
      $display("FAIL reset_dark: got an lit within 3 frames, required an=f throughout");
    end
    checks++;
    if (first_m != 32 || first_z != 32) begin
      failures++;
      $display("FAIL first_frame_start: got cycle %0d/%0d, required 32", first_m, first_z);
    end
    checks++;
    if (first_t != 8) begin
      failures++;
      $display("FAIL first_frame_start_div2: got cycle %0d, required 8", first_t);
    end
  endtask

  task automatic test_basic();
    logic [11:0] e;
    do_load(16'h12AF, 4'b0100, 4'hF);
    wait_fs(0);
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h12AF, 4'b0100, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL basic p=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 p, an_m, seg_m, dp_m, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [11:0] e;
    do_load(16'h0000, 4'b0000, 4'hF);
    wait_fs(0);
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h0000, 4'b0000, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL no_tear_old p=%0d: got an=%b seg=%b, required an=%b seg=%b",
                 p, an_m, seg_m, e[11:8], e[7:1]);
      end
      checks++;
      if (fs_m !== (p == 32)) begin
        failures++;
        $display("FAIL frame_start p=%0d: got %b, required %b", p, fs_m, (p == 32));
      end
      if (p == 10) begin
        data_in = 16'h8888;
        load = 1'b1;
      end
      if (p == 11) load = 1'b0;
    end
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h8888, 4'b0000, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL no_tear_new p=%0d: got an=%b seg=%b, required an=%b seg=%b",
                 p, an_m, seg_m, e[11:8], e[7:1]);
      end
    end
  endtask

  // Entered on the frame_start cycle left by test_no_tearing; shadow holds 8888.
  task automatic test_simultaneous();
    logic [11:0] e;
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h8888, 4'b0000, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL simul_pre p=%0d: got an=%b seg=%b, required an=%b seg=%b",
                 p, an_m, seg_m, e[11:8], e[7:1]);
      end
      if (p == 5) begin data_in = 16'h1111; load = 1'b1; end
      if (p == 6) load = 1'b0;
      if (p == 31) begin data_in = 16'h2222; load = 1'b1; end
      if (p == 32) load = 1'b0;
    end
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h2222, 4'b0000, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL simul_bypass p=%0d: got an=%b seg=%b, required an=%b seg=%b",
                 p, an_m, seg_m, e[11:8], e[7:1]);
      end
      if (p == 31) begin data_in = 16'h3333; load = 1'b1; end
      if (p == 32) load = 1'b0;
    end
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h3333, 4'b0000, 4'hF, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL simul_nopend p=%0d: got an=%b seg=%b, required an=%b seg=%b",
                 p, an_m, seg_m, e[11:8], e[7:1]);
      end
    end
  endtask

  task automatic test_digit_en();
    logic [11:0] e;
    do_load(16'h5A3C, 4'b1111, 4'b1010);
    wait_fs(0);
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'h5A3C, 4'b1111, 4'b1010, (p - 1) / 8, (p - 1) % 8, 2);
      checks++;
      if ({an_m, seg_m, dp_m} !== e) begin
        failures++;
        $display("FAIL digit_en p=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 p, an_m, seg_m, dp_m, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_blank_zero();
    logic [11:0] e;
    do_load(16'hABCD, 4'b0001, 4'hF);
    wait_fs(1);
    for (int p = 1; p <= 32; p++) begin
      @(negedge clk);
      e = exp_out(16'hABCD, 4'b0001, 4'hF, (p - 1) / 8, (p - 1) % 8, 0);
      checks++;
      if ({an_z, seg_z, dp_z} !== e) begin
        failures++;
        $display("FAIL blank_zero p=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 p, an_z, seg_z, dp_z, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_scan_div2();
    logic [11:0] e;
    do_load(16'h4321, 4'b1000, 4'hF);
    wait_fs(2);
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      e = exp_out(16'h4321, 4'b1000, 4'hF, ((p - 1) / 2) % 4, (p - 1) % 2, 1);
      checks++;
      if ({an_t, seg_t, dp_t} !== e) begin
        failures++;
        $display("FAIL div2 p=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 p, an_t, seg_t, dp_t, e[11:8], e[7:1], e[0]);
      end
      checks++;
      if (fs_t !== (p % 8 == 0)) begin
        failures++;
        $display("FAIL div2_frame_start p=%0d: got %b, required %b", p, fs_t, (p % 8 == 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_m;
    logic lit;
    wait_fs(0);
    for (int p = 1; p <= 7; p++) begin
      @(negedge clk);
      if (p == 5) begin data_in = 16'h7777; load = 1'b1; end
      if (p == 6) load = 1'b0;
    end
    // Shadow holds 4321 from the previous test: digit 0 is '1', in its drive phase now.
    checks++;
    if (an_m !== 4'b1110 || seg_m !== 7'b1111001) begin
      failures++;
      $display("FAIL pre_reset_drive: got an=%b seg=%b, required an=1110 seg=1111001",
               an_m, seg_m);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({an_m, seg_m, dp_m, fs_m} !== {4'hF, 7'h7F, 1'b1, 1'b0} ||
        {an_z, seg_z, dp_z, fs_z} !== {4'hF, 7'h7F, 1'b1, 1'b0} ||
        {an_t, seg_t, dp_t, fs_t} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got an=%b seg=%b dp=%b fs=%b, required an=1111 seg=1111111 dp=1 fs=0",
               an_m, seg_m, dp_m, fs_m);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_m = -1;
    lit = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (fs_m && first_m < 0) first_m = k;
      if (an_m !== 4'hF) lit = 1'b1;
    end
    checks++;
    if (lit !== 1'b0) begin
      failures++;
      $display("FAIL pending_lost: got an lit after reset, required an=f (pending load cleared)");
    end
    checks++;
    if (first_m != 32) begin
      failures++;
      $display("FAIL frame_start_after_reset: got cycle %0d, required 32", first_m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_tearing();
    test_simultaneous();
    test_digit_en();
    test_blank_zero();
    test_scan_div2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It holds a double-buffered 16-bit hex value, scans one digit per slot from an internal prescaler, and blanks each slot's first cycles to suppress ghosting. Runs on the system clock and uses a scan counter rather than a derived clock. The upstream logic writes values with a single-cycle `load` strobe. New values appear only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- `SCAN_DIV`, default 25000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 100: cycles at the start of each slot with all anodes off. Must be < `SCAN_DIV`; 0 disables blanking.

Ports:
- `clk_in`  in  1: system clock. Everything is clocked on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  16: four hex nibbles; digit i = `data_in[4i+3:4i]`.
- `dp_in`  in  4: decimal point per digit, 1 = lit.
- `digit_en`  in  4: per-digit enable, 0 = digit dark.
- `load`  in  1: single-cycle strobe that captures `data_in`, `dp_in` and `digit_en`.
- `an`  out  4: anodes, active-low.
- `seg`  out  7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1: decimal-point cathode, active-low.
- `frame_start`  out  1: one-cycle pulse when the shadow registers update / digit 0 begins.

## Operation
- **Prescaler `cnt`:** counts 0..`SCAN_DIV`-1, then wraps to 0. On each wrap, digit index `idx` advances 0→1→2→3→0.
- **Frame boundary:** the cycle where `cnt` wraps while `idx`=3.
- **Pending registers:** a `load` copies `data_in`/`dp_in`/`digit_en` into them and sets `pend`=1. A later `load` before the boundary overwrites them; last write wins.
- **At the boundary:**
  - If `load`=1 in that same cycle, the inputs go directly to the shadow registers and `pend` clears. The bypass takes priority.
  - Otherwise, if `pend`=1, pending is copied to shadow and `pend` clears.
  - Otherwise shadow is unchanged.
- **Blank phase** (`cnt` < `BLANK_CYCLES`): `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- **Drive phase:**
  - `an[idx]`=0 only if shadow `digit_en[idx]`=1; other anodes are 1.
  - `seg` = hex decode of shadow nibble `idx`.
  - `dp` = ~shadow `dp[idx]`.
  - If the digit is disabled: `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- **Hex decode table** (`{g..a}`, active-low):

  | Value | Pattern | Value | Pattern | Value | Pattern | Value | Pattern |
  |---|---|---|---|---|---|---|---|
  | 0 | 1000000 | 1 | 1111001 | 2 | 0100100 | 3 | 0110000 |
  | 4 | 0011001 | 5 | 0010010 | 6 | 0000010 | 7 | 1111000 |
  | 8 | 0000000 | 9 | 0010000 | A | 0001000 | b | 0000011 |
  | C | 1000110 | d | 0100001 | E | 0000110 | F | 0001110 |

- **Reset values:** `cnt`=0, `idx`=0, shadow and pending = 0 (including `digit_en`), `pend`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_start`=0. The display stays dark until the first load reaches shadow.
- **Reset mid-operation:** all state clears immediately, asynchronously. A pending load is lost.

## Timing
- `an`, `seg`, `dp` and `frame_start` are registered. They reflect the `cnt`/`idx`/shadow state one cycle earlier.
- After reset deasserts, slot k (k = 0..3) covers cycles `k*SCAN_DIV` .. `(k+1)*SCAN_DIV-1` after the first post-reset clock edge. Outputs lag by one cycle.
- Frame length is `4*SCAN_DIV` cycles.
- No `frame_start` pulse is generated on reset exit. The first pulse appears at output 1 cycle after the first boundary.
- **Load-to-display latency:** from the next boundary, plus the 1-cycle output register, plus `BLANK_CYCLES`, until the anode drives. Worst case is about `4*SCAN_DIV+BLANK_CYCLES+1` cycles.
- `load` is level-sampled every cycle. Holding it high for N cycles is equivalent to the last cycle's load.
- `frame_start` is high for exactly 1 cycle per frame.

## Test plan
Use `SCAN_DIV`=8, `BLANK_CYCLES`=2.

1. **Reset:** assert `rst` asynchronously mid-slot → outputs are immediately `an`=F, `seg`=7F, `dp`=1, `frame_start`=0. With no `load`, `an` stays F for 3 frames.
2. **Basic display:** pulse `load` with `data_in`=16'h12AF, `dp_in`=4'b0100, `digit_en`=4'hF → after the next `frame_start`:
   - Per slot: 2 blank cycles, then 6 cycles of drive.
   - Digit 0: `an`=1110, `seg`=0001110.
   - Digit 1: `an`=1101, `seg`=0001000.
   - Digit 2: `an`=1011, `seg`=0100100, `dp`=0.
   - Digit 3: `an`=0111, `seg`=1111001.
3. **No tearing:** with 16'h0000 displayed, `load` 16'h8888 during slot 1 → slots 2 and 3 still show `seg`=1000000. The following frame shows 0000000 on all digits.
4. **Simultaneous events:**
   - `load`(16'h1111) mid-frame, then `load`(16'h2222) in the boundary cycle → next frame shows 2 on all digits.
   - With `pend`=0, a `load` at the boundary is also taken immediately.
5. **Digit enable:** `digit_en`=4'b1010 → `an` never drives digits 0 or 2 (stays 1111 in their slots). Digits 1 and 3 are driven normally.
6. **Boundary parameters:**
   - `BLANK_CYCLES`=0 → the anode is active on every slot cycle.
   - `SCAN_DIV`=2 → `frame_start` period is 8 cycles, and `idx` wraps 3→0 correctly.
